// File: rtl/ahbl_stream_writer.sv
// -----------------------------------------------------------------------------
// ahbl_stream_writer
//
// AHB-Lite master that drains a valid/ready word stream into consecutive
// memory words using back-to-back NONSEQ single writes. Address and data
// phases are pipelined through two slots (address-phase slot "ap", data-phase
// slot "dp"), so with a zero-wait-state slave one word is written per cycle.
//
// Optional feature macro: AHBL_STREAM_WRITER_ERR_EN
//   defined   : a two-cycle ERROR response aborts the transfer, sets the
//               sticky err flag and pulses done.
//   undefined : hresp is ignored, err is tied low, and error responses
//               behave like ordinary wait states.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               begin transfer (sampled only while busy=0)
//   base_addr, len      first word address / word count, sampled with start
//   busy, done, err     status: in progress / end pulse / sticky bus error
//   s_valid, s_ready,
//   s_data              input word stream
//   ahblm_*             AHB-Lite master interface
// -----------------------------------------------------------------------------
module ahbl_stream_writer #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 32,
    parameter int W_LEN  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_ADDR-1:0] base_addr,
    input  logic [W_LEN-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W_DATA-1:0] s_data,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp
);

    localparam logic [W_ADDR-1:0] ADDR_STEP     = W_ADDR'(W_DATA / 8);
    localparam logic [W_ADDR-1:0] ADDR_LSB_MASK = ADDR_STEP - W_ADDR'(1);
    localparam logic [2:0]        HSIZE         = 3'($clog2(W_DATA / 8));
    localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
    localparam logic [W_LEN-1:0]  LEN_ONE       = W_LEN'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [W_LEN-1:0]    issue_cnt_reg, issue_cnt_next;   // words still to accept
    logic [W_LEN-1:0]    rem_cnt_reg, rem_cnt_next;       // data phases still to complete
    logic [W_ADDR-1:0]   addr_reg, addr_next;
    logic                ap_valid_reg, ap_valid_next;
    logic [W_DATA-1:0]   ap_data_reg, ap_data_next;
    logic                dp_valid_reg, dp_valid_next;
    logic [W_DATA-1:0]   dp_data_reg, dp_data_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    logic                s_hs;
    logic                ap_done;
    logic                dp_done;

`ifdef AHBL_STREAM_WRITER_ERR_EN
    // First cycle of a two-cycle ERROR response on our data phase.
    logic err_hit;
    assign err_hit = dp_valid_reg & ahblm_hresp & ~ahblm_hready;
    // Accepting a word while the bus is erroring would only lose it.
    assign s_ready = (state_reg == ST_RUN) & (issue_cnt_reg != '0)
                   & (~ap_valid_reg | ahblm_hready) & ~err_hit;
`else
    logic unused_hresp;
    assign unused_hresp = ahblm_hresp;
    assign s_ready = (state_reg == ST_RUN) & (issue_cnt_reg != '0)
                   & (~ap_valid_reg | ahblm_hready);
`endif

    assign s_hs    = s_valid & s_ready;
    assign ap_done = ap_valid_reg & ahblm_hready;
    assign dp_done = dp_valid_reg & ahblm_hready;

    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        rem_cnt_next   = rem_cnt_reg;
        addr_next      = addr_reg;
        ap_valid_next  = ap_valid_reg;
        ap_data_next   = ap_data_reg;
        dp_valid_next  = dp_valid_reg;
        dp_data_next   = dp_data_reg;
        done_next      = 1'b0;
        err_next       = err_reg;

        // Pipeline advance: everything moves only while the bus is ready,
        // which keeps address and data phase signals frozen on wait states.
        if (ahblm_hready) begin
            dp_valid_next = ap_valid_reg;
            if (ap_valid_reg) begin
                dp_data_next = ap_data_reg;
            end
            ap_valid_next = 1'b0;
        end

        if (ap_done) begin
            addr_next = addr_reg + ADDR_STEP;
        end

        // A handshake refills the address slot (s_ready guarantees it is
        // free or being vacated this cycle).
        if (s_hs) begin
            ap_valid_next  = 1'b1;
            ap_data_next   = s_data;
            issue_cnt_next = issue_cnt_reg - LEN_ONE;
        end

        if (dp_done && (rem_cnt_reg != '0)) begin
            rem_cnt_next = rem_cnt_reg - LEN_ONE;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    err_next = 1'b0;
                    if (len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next     = ST_RUN;
                        issue_cnt_next = len;
                        rem_cnt_next   = len;
                        addr_next      = base_addr & ~ADDR_LSB_MASK;
                    end
                end
            end
            ST_RUN: begin
                if (s_hs && (issue_cnt_reg == LEN_ONE)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dp_done && (rem_cnt_reg == LEN_ONE)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef AHBL_STREAM_WRITER_ERR_EN
        // Abort: withdraw the pending address phase so htrans is IDLE in
        // the second error cycle; the erroring data phase still retires
        // through the normal hready path.
        if (err_hit && (state_reg != ST_IDLE)) begin
            ap_valid_next  = 1'b0;
            issue_cnt_next = '0;
            rem_cnt_next   = '0;
            state_next     = ST_IDLE;
            done_next      = 1'b1;
            err_next       = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            issue_cnt_reg <= '0;
            rem_cnt_reg   <= '0;
            addr_reg      <= '0;
            ap_valid_reg  <= 1'b0;
            ap_data_reg   <= '0;
            dp_valid_reg  <= 1'b0;
            dp_data_reg   <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            issue_cnt_reg <= issue_cnt_next;
            rem_cnt_reg   <= rem_cnt_next;
            addr_reg      <= addr_next;
            ap_valid_reg  <= ap_valid_next;
            ap_data_reg   <= ap_data_next;
            dp_valid_reg  <= dp_valid_next;
            dp_data_reg   <= dp_data_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign busy            = (state_reg != ST_IDLE);
    assign done            = done_reg;
    assign err             = err_reg;
    assign ahblm_haddr     = addr_reg;
    assign ahblm_htrans    = ap_valid_reg ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahblm_hwdata    = dp_data_reg;
    assign ahblm_hwrite    = 1'b1;
    assign ahblm_hsize     = HSIZE;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;

endmodule

// File: tb/tb_ahbl_stream_writer.sv
module tb_ahbl_stream_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;

    int tests_run = 0;
    int fail_cnt  = 0;

    // Stream source state
    int          src_idx;
    logic [31:0] data_base;

    // Slave memory model
    logic [31:0] mem [0:255];
    logic        pend;
    logic [31:0] pend_addr;
    int          wr_cnt;

    ahbl_stream_writer #(
        .W_DATA(32),
        .W_ADDR(32),
        .W_LEN (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .ahblm_haddr    (haddr),
        .ahblm_hwrite   (hwrite),
        .ahblm_htrans   (htrans),
        .ahblm_hsize    (hsize),
        .ahblm_hburst   (hburst),
        .ahblm_hprot    (hprot),
        .ahblm_hmastlock(hmastlock),
        .ahblm_hwdata   (hwdata),
        .ahblm_hready   (hready),
        .ahblm_hresp    (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency SRAM slave: latch address phase, write on data phase.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            wr_cnt <= 0;
        end else if (hready) begin
            if (pend) begin
                mem[pend_addr[9:2]] <= hwdata;
                wr_cnt <= wr_cnt + 1;
                $display("[TB] write addr=%08h data=%08h", pend_addr, hwdata);
            end
            pend      <= (htrans == 2'b10);
            pend_addr <= haddr;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake late in the cycle, then advance the
    // source after the edge so the DUT has captured the old word.
    task automatic tick();
        logic hs;
        #3;
        hs = s_valid & s_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            src_idx++;
            s_data = data_base + 32'(src_idx);
        end
    endtask

    task automatic new_stream(input logic [31:0] b);
        data_base = b;
        src_idx   = 0;
        s_data    = b;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int wr0;
        int seen;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        s_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
        new_stream(32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state and constant outputs
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_err",    64'(err),    64'd0);
        check("rst_sready", 64'(s_ready), 64'd0);
        check("rst_htrans", 64'(htrans), 64'd0);
        check("rst_haddr",  64'(haddr),  64'd0);
        check("rst_hwdata", 64'(hwdata), 64'd0);
        check("c_hwrite",   64'(hwrite), 64'd1);
        check("c_hsize",    64'(hsize),  64'd2);
        check("c_hburst",   64'(hburst), 64'd0);
        check("c_hprot",    64'(hprot),  64'd3);
        check("c_mlock",    64'(hmastlock), 64'd0);
        rst = 1'b0;
        tick();

        // 1: base 0x100, len 4, zero wait states
        new_stream(32'hA100_0000);
        s_valid = 1'b1;
        do_start(32'h100, 16'd4);
        check("t1_busy",  64'(busy),   64'd1);
        check("t1_idle0", 64'(htrans), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_htrans", 64'(htrans), 64'd2);
            check("t1_haddr",  64'(haddr),  64'(32'h100 + 32'(4 * k)));
            if (k > 0) check("t1_hwdata", 64'(hwdata), 64'(32'hA100_0000 + 32'(k - 1)));
        end
        tick();
        check("t1_idle_end", 64'(htrans), 64'd0);
        check("t1_hwdata3",  64'(hwdata), 64'h0A100_0003);
        check("t1_nodone",   64'(done),   64'd0);
        tick();
        check("t1_done",  64'(done), 64'd1);
        check("t1_busy0", 64'(busy), 64'd0);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) check("t1_mem", 64'(mem[64 + i]), 64'(32'hA100_0000 + 32'(i)));

        // 2: same transfer, 2 wait states during the 2nd data phase
        new_stream(32'hB200_0000);
        do_start(32'h100, 16'd4);
        tick(); tick(); tick();
        check("t2_dp2_hwdata", 64'(hwdata), 64'h0B200_0001);
        hready = 1'b0;
        #1;
        check("t2_sready_ws", 64'(s_ready), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t2_hold_haddr",  64'(haddr),  64'h108);
            check("t2_hold_htrans", 64'(htrans), 64'd2);
            check("t2_hold_hwdata", 64'(hwdata), 64'h0B200_0001);
        end
        hready = 1'b1;
        tick();
        check("t2_haddr3",  64'(haddr),  64'h10C);
        check("t2_hwdata2", 64'(hwdata), 64'h0B200_0002);
        wait_done("t2_done", 20);
        for (int i = 0; i < 4; i++) check("t2_mem", 64'(mem[64 + i]), 64'(32'hB200_0000 + 32'(i)));

        // 3: s_valid toggling 1,0,1,0 -> interleaved IDLE transfers
        new_stream(32'hC300_0000);
        wr0 = wr_cnt;
        s_valid = 1'b0;
        do_start(32'h140, 16'd4);
        for (int k = 0; k < 8; k++) begin
            s_valid = (k % 2 == 0);
            tick();
            check("t3_htrans", 64'(htrans), (k % 2 == 0) ? 64'd2 : 64'd0);
            if (k % 2 == 0) check("t3_haddr", 64'(haddr), 64'(32'h140 + 32'(4 * (k / 2))));
        end
        wait_done("t3_done", 20);
        check("t3_wrcnt", 64'(wr_cnt - wr0), 64'd4);
        for (int i = 0; i < 4; i++) check("t3_mem", 64'(mem[80 + i]), 64'(32'hC300_0000 + 32'(i)));

        // 4: address wrap
        new_stream(32'hD400_0000);
        s_valid = 1'b1;
        do_start(32'hFFFF_FFFC, 16'd2);
        tick();
        check("t4_haddr0", 64'(haddr), 64'hFFFF_FFFC);
        tick();
        check("t4_htrans1", 64'(htrans), 64'd2);
        check("t4_haddr1",  64'(haddr),  64'h0);
        wait_done("t4_done", 20);
        check("t4_mem0", 64'(mem[255]), 64'h0D400_0000);
        check("t4_mem1", 64'(mem[0]),   64'h0D400_0001);

        // 5: len=0, then start while busy is ignored
        do_start(32'h180, 16'd0);
        check("t5_done",   64'(done),   64'd1);
        check("t5_busy",   64'(busy),   64'd0);
        check("t5_htrans", 64'(htrans), 64'd0);
        tick();
        check("t5_done_pulse", 64'(done), 64'd0);
        new_stream(32'hE500_0000);
        wr0 = wr_cnt;
        do_start(32'h180, 16'd2);
        start = 1'b1; base_addr = 32'h200; len = 16'd5;
        tick();
        start = 1'b0;
        wait_done("t5b_done", 20);
        check("t5b_wrcnt", 64'(wr_cnt - wr0), 64'd2);
        check("t5b_mem0",  64'(mem[96]), 64'h0E500_0000);
        check("t5b_mem1",  64'(mem[97]), 64'h0E500_0001);
        tick(); tick();
        check("t5b_idle", 64'(busy), 64'd0);

        // 6: two-cycle error response on the 2nd data phase
        new_stream(32'hF600_0000);
        wr0 = wr_cnt;
        do_start(32'h1C0, 16'd4);
        tick(); tick(); tick();
        hready = 1'b0; hresp = 1'b1;
        #1;
        check("t6_sready_e1", 64'(s_ready), 64'd0);
        tick();
`ifdef AHBL_STREAM_WRITER_ERR_EN
        check("t6_htrans_e2", 64'(htrans),  64'd0);
        check("t6_err",       64'(err),     64'd1);
        check("t6_done",      64'(done),    64'd1);
        check("t6_sready",    64'(s_ready), 64'd0);
        hready = 1'b1;
        tick();
        hresp = 1'b0;
        check("t6_done_pulse", 64'(done), 64'd0);
        check("t6_err_sticky", 64'(err),  64'd1);
`else
        check("t6_hold_htrans", 64'(htrans), 64'd2);
        check("t6_hold_haddr",  64'(haddr),  64'h1C8);
        check("t6_hold_hwdata", 64'(hwdata), 64'h0F600_0001);
        check("t6_err0",        64'(err),    64'd0);
        hready = 1'b1;
        tick();
        hresp = 1'b0;
        wait_done("t6_done", 20);
        check("t6_err_after", 64'(err), 64'd0);
        check("t6_wrcnt", 64'(wr_cnt - wr0), 64'd4);
        for (int i = 0; i < 4; i++) check("t6_mem", 64'(mem[112 + i]), 64'(32'hF600_0000 + 32'(i)));
`endif

        // Reset mid-transfer
        new_stream(32'h1700_0000);
        do_start(32'h100, 16'd4);
        check("r_err_cleared", 64'(err), 64'd0);
        tick(); tick();
        check("r_active", 64'(htrans), 64'd2);
        rst = 1'b1;
        #1;
        check("r_busy",   64'(busy),    64'd0);
        check("r_done",   64'(done),    64'd0);
        check("r_sready", 64'(s_ready), 64'd0);
        check("r_htrans", 64'(htrans),  64'd0);
        check("r_haddr",  64'(haddr),   64'd0);
        check("r_hwdata", 64'(hwdata),  64'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1 || htrans !== 2'b00) seen++;
        end
        check("r_quiet", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
